line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//  Main-memory responder at the memory-side end of the L2 line interface.
//  Accepts single-line (128-bit) read/write requests addressed by 28-bit line address,
//  models a fixed access latency, answers each request with a one-cycle mem_ready pulse.
//  Serves as simulation memory and FPGA block-RAM backing store below the L2 cache.
// PARAMETERS
//  ADDR_W      28   line address width (word address >> 2)
//  LINE_W      128  line width, 4 x 32-bit words
//  DEPTH_LOG2  8    log2(number of stored lines); array = 2**DEPTH_LOG2 x LINE_W
//  LATENCY     4    cycles from request sample to mem_ready; legal range 1..15
// PORTS
//  clk          in   1       clock, all state on rising edge
//  proc_reset_n in   1       asynchronous active-low reset
//  mem_read     in   1       read request, held by initiator until mem_ready
//  mem_write    in   1       write request, held by initiator until mem_ready
//  mem_addr     in   ADDR_W  line address, stable while request held
//  mem_wdata    in   LINE_W  write line data, stable while mem_write held
//  mem_ready    out  1       one-cycle completion pulse (registered)
//  mem_rdata    out  LINE_W  read line; valid only in mem_ready cycle of a read (registered)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, counter=0, mem_ready=0, mem_rdata=0.
//    Array contents are NOT reset. Reset mid-access aborts it; a pending write is not committed.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if mem_read^mem_write, latch op/addr/wdata, cnt=LATENCY-1; go BUSY (LATENCY>1) or RESP (LATENCY=1).
//          mem_read&mem_write (illegal) or neither: stay IDLE, no side effects.
//    BUSY: cnt decrements each cycle; at cnt==1 go RESP. Request inputs ignored.
//    RESP: mem_ready=1 for exactly this cycle. Write: array[idx]<=latched wdata at end of cycle.
//          Read: mem_rdata=array[idx] (write-through of same-cycle commit not needed; one op at a time).
//          Next state IDLE unconditionally.
//  - Latency: request first seen in IDLE at cycle T -> mem_ready high in cycle T+LATENCY.
//  - Back-to-back: initiator may present a new request the cycle after mem_ready
//    (write-back then refill); IDLE samples it, so turnaround is LATENCY+1 cycles per access.
//  - Latched values govern the access; input changes after sampling are ignored.
//    Request dropped before mem_ready: access still completes and mem_ready still pulses.
//  - idx = latched mem_addr[DEPTH_LOG2-1:0]; upper address bits alias (wrap), no error.
//  - mem_rdata is 0 in every cycle other than a read's RESP cycle; mem_ready never high in IDLE/BUSY.
//  - Read-after-write to same line returns the written data (write committed before next IDLE sample).
// CONFIGURATION
//  MEM_STATS_EN defined: adds outputs rd_count[15:0], wr_count[15:0]; each increments in the
//    RESP cycle of its op type, saturates at 16'hFFFF, reset to 0 asynchronously.
//  MEM_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset low 3 cycles, release -> mem_ready=0, mem_rdata=0 for 10 idle cycles.
//  2. Write addr 28'h0000012, data 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D held; ready exactly cycle T+4;
//     then read same addr -> mem_ready at T'+4 with that data, mem_rdata=0 the cycle before/after.
//  3. Write 28'h0000005 data A, next cycle after ready read 28'h0000007 (prefilled B) -> two pulses 5 cycles
//     apart, read returns B; A persists on later read of 28'h0000005.
//  4. Alias: write 28'h0000103 data C, read 28'h0000003 -> returns C (DEPTH_LOG2=8).
//  5. mem_read=mem_write=1 for 6 cycles -> no mem_ready, array unchanged; reset asserted in BUSY of a
//     write to 28'h0000009 -> no mem_ready, subsequent read returns prior contents.
//  6. MEM_STATS_EN: 3 writes + 2 reads -> wr_count=3, rd_count=2; illegal request adds nothing.

Source files
------------

// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder: fixed-latency single-line read/write with a one-cycle ready pulse.
// Optional MEM_STATS_EN adds saturating read/write completion counters (rd_count, wr_count).
module line_mem_responder #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  // Handshake: a request (exactly one of mem_read/mem_write) is held with stable
  // address/data until mem_ready pulses for one cycle; the request is sampled only
  // in IDLE, so everything after sampling is ignored until the response.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [3:0]            w_next_cnt;
  logic                  w_accept;
  logic                  r_op_write;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [LINE_W-1:0]     r_wdata;
  logic                  r_ready;
  logic [LINE_W-1:0]     r_rdata;
  logic                  w_resp_write;
  logic [DEPTH_LOG2-1:0] w_resp_idx;
  logic [LINE_W-1:0]     r_mem [2**DEPTH_LOG2];

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          w_accept     = 1'b1;
          w_next_cnt   = LAT_M1;
          w_next_state = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        w_next_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // With LATENCY=1 the response follows straight from IDLE, so use the live request.
  assign w_resp_write = w_accept ? mem_write : r_op_write;
  assign w_resp_idx   = w_accept ? mem_addr[DEPTH_LOG2-1:0] : r_idx;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_op_write <= mem_write;
        r_idx      <= mem_addr[DEPTH_LOG2-1:0];
        r_wdata    <= mem_wdata;
      end
      r_ready <= (w_next_state == RESP);
      r_rdata <= ((w_next_state == RESP) && !w_resp_write) ? r_mem[w_resp_idx] : '0;
    end
  end

  // Array has no reset; a write commits only at the end of its RESP cycle.
  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_op_write) r_mem[r_idx] <= r_wdata;
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign dbg_state = r_state;

`ifdef MEM_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (r_state == RESP) begin
      if (!r_op_write && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
      if (r_op_write && (r_wr_count != 16'hFFFF))  r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: vector table of line accesses plus hand sequences
// for back-to-back turnaround, illegal requests, and reset during an access.
module tb_line_mem_responder;

  localparam logic [127:0] D_DEAD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D_A    = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [127:0] D_B    = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
  localparam logic [127:0] D_C    = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
  localparam logic [127:0] D_D    = 128'h0D0D0D0D_12345678_9ABCDEF0_0F0F0F0F;
  localparam logic [127:0] D_E    = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;
  localparam logic [127:0] D_P    = 128'h50505050_60606060_70707070_80808080;

  logic          clk;
  logic          proc_reset_n;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic          mem_ready;
  logic [127:0]  mem_rdata;
  logic [1:0]    dbg_state;
`ifdef MEM_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`endif

  int n_checks;
  int n_errors;
  int cyc;
  int exp_rd;
  int exp_wr;
  logic [127:0] exp_q[$];

  line_mem_responder dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
`ifdef MEM_STATS_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drivers
  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", {127'd0, mem_ready}, 128'd0);
      chk("idle_rdata", mem_rdata, 128'd0);
      chk("idle_state", {126'd0, dbg_state}, 128'd0);
    end
  endtask

  // Leaves the request asserted; the caller clears it or issues the next one.
  task automatic do_access(input logic wr, input logic [27:0] a, input logic [127:0] d,
                           output logic [127:0] rd, output int lat, output int at_cyc);
    logic pre_bad;
    @(posedge clk);
    #1;
    mem_read  = !wr;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    lat       = -1;
    at_cyc    = -1;
    rd        = '0;
    pre_bad   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_ready) begin
        lat    = c;
        at_cyc = cyc;
        rd     = mem_rdata;
        break;
      end
      if (mem_rdata !== 128'd0) pre_bad = 1'b1;
    end
    chk("latency", 128'(lat), 128'd4);
    chk("rdata_before_ready", {127'd0, pre_bad}, 128'd0);
    if (lat >= 0) begin
      if (wr) exp_wr++;
      else    exp_rd++;
    end
  endtask

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [127:0] rd;
    int           lat;
    int           c0;
    int           c1;

    vecs[0] = '{1'b1, 28'h0000012, D_DEAD, 128'd0};
    vecs[1] = '{1'b0, 28'h0000012, 128'd0, D_DEAD};
    vecs[2] = '{1'b1, 28'h0000007, D_B,    128'd0};
    vecs[3] = '{1'b1, 28'h0000103, D_C,    128'd0};
    vecs[4] = '{1'b0, 28'h0000003, 128'd0, D_C};
    vecs[5] = '{1'b0, 28'h0000007, 128'd0, D_B};
    vecs[6] = '{1'b1, 28'h00000FF, D_D,    128'd0};
    vecs[7] = '{1'b0, 28'h00001FF, 128'd0, D_D};

    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    exp_rd       = 0;
    exp_wr       = 0;
    proc_reset_n = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    proc_reset_n = 1'b1;
    idle_cycles(10);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].wr) exp_q.push_back(vecs[i].exp_rdata);
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat, c0);
      if (vecs[i].wr) chk("write_rdata_zero", rd, 128'd0);
      else            chk("read_data", rd, exp_q.pop_front());
      idle_cycles(1);
    end

    // write-back then refill, back to back
    do_access(1'b1, 28'h0000005, D_A, rd, lat, c0);
    exp_q.push_back(D_B);
    do_access(1'b0, 28'h0000007, 128'd0, rd, lat, c1);
    chk("b2b_spacing", 128'(c1 - c0), 128'd5);
    chk("b2b_read", rd, exp_q.pop_front());
    idle_cycles(1);
    exp_q.push_back(D_A);
    do_access(1'b0, 28'h0000005, 128'd0, rd, lat, c0);
    chk("persist_read", rd, exp_q.pop_front());
    idle_cycles(1);

    // illegal read+write: no response, array untouched
    @(posedge clk);
    #1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 28'h0000012;
    mem_wdata = D_E;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("illegal_ready", {127'd0, mem_ready}, 128'd0);
      chk("illegal_state", {126'd0, dbg_state}, 128'd0);
    end
    idle_cycles(2);
    do_access(1'b0, 28'h0000012, 128'd0, rd, lat, c0);
    chk("illegal_unchanged", rd, D_DEAD);
    idle_cycles(1);

    // reset during BUSY of a write aborts it
    do_access(1'b1, 28'h0000009, D_P, rd, lat, c0);
    idle_cycles(1);
    @(posedge clk);
    #1;
    mem_write = 1'b1;
    mem_addr  = 28'h0000009;
    mem_wdata = D_E;
    @(negedge clk);
    @(negedge clk);
    chk("busy_state", {126'd0, dbg_state}, 128'd1);
    proc_reset_n = 1'b0;
    mem_write    = 1'b0;
    exp_rd       = 0;
    exp_wr       = 0;
    #1;
    chk("reset_state", {126'd0, dbg_state}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_ready", {127'd0, mem_ready}, 128'd0);
    end
    @(posedge clk);
    #1;
    proc_reset_n = 1'b1;
    idle_cycles(4);
    do_access(1'b0, 28'h0000009, 128'd0, rd, lat, c0);
    chk("abort_prior_data", rd, D_P);
    idle_cycles(1);

`ifdef MEM_STATS_EN
    // after reset: 3 writes + 2 reads, with an illegal request in between
    do_access(1'b1, 28'h0000020, D_A, rd, lat, c0);
    do_access(1'b1, 28'h0000021, D_B, rd, lat, c0);
    idle_cycles(1);
    @(posedge clk);
    #1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    idle_cycles(2);
    do_access(1'b1, 28'h0000022, D_C, rd, lat, c0);
    do_access(1'b0, 28'h0000020, 128'd0, rd, lat, c0);
    idle_cycles(2);
    chk("rd_count", 128'(rd_count), 128'(exp_rd));
    chk("wr_count", 128'(wr_count), 128'(exp_wr));
    chk("rd_count_abs", 128'(rd_count), 128'd2);
    chk("wr_count_abs", 128'(wr_count), 128'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
